// File: rtl/ucore_main.sv
// ucore_main: UART-driven memory access core.
// Receives command bytes over a UART register interface and performs
// address/count setup, memory-to-TX block reads and RX-to-memory block writes.
// Ports:
//   clk, aresetn                  clock, asynchronous active-low reset
//   uart_interrupt                one-cycle pulse: an RX byte is available
//   uart_rcen/uart_rack/uart_rdata  UART register read handshake (one-hot select)
//   uart_wcen/uart_wack/uart_wdata  UART register write handshake (one-hot select)
//   mem_cen/mem_wen/mem_ack       memory request, direction, acknowledge
//   mem_addr/mem_wdata/mem_rdata  memory byte address, write data, read data
`timescale 1ns/1ps
module ucore_main (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        uart_interrupt,
  output logic [3:0]  uart_rcen,
  input  logic        uart_rack,
  input  logic [7:0]  uart_rdata,
  output logic [3:0]  uart_wcen,
  input  logic        uart_wack,
  output logic [7:0]  uart_wdata,
  output logic        mem_cen,
  output logic        mem_wen,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned REG_W  = 4;

  localparam logic [REG_W-1:0]  REG_RX = 4'b0001;
  localparam logic [REG_W-1:0]  REG_TX = 4'b0010;

  localparam logic [BYTE_W-1:0] CMD_SET_ADDR  = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_SET_COUNT = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_READ_MEM  = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_WRITE_MEM = 8'h04;

  typedef enum logic [3:0] {
    IDLE, CMD_RD, DECODE, ARG_WAIT, ARG_RD,
    MEM_RD, TX_WR, DATA_WAIT, DATA_RD, MEM_WR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   count_q, count_d;
  logic                pend_q, pend_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [1:0]          arg_idx_q, arg_idx_d;
  logic [23:0]         arg_sh_q, arg_sh_d;
  logic [BYTE_W-1:0]   xfer_q, xfer_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [REG_W-1:0]    rcen_q, rcen_d;
  logic [REG_W-1:0]    wcen_q, wcen_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                mcen_q, mcen_d;
  logic                mwen_q, mwen_d;
  logic                rd_issue;

  // Next-state and request generation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    cmd_d     = cmd_q;
    arg_idx_d = arg_idx_q;
    arg_sh_d  = arg_sh_q;
    xfer_d    = xfer_q;
    rx_d      = rx_q;
    rcen_d    = rcen_q;
    wcen_d    = wcen_q;
    wdata_d   = wdata_q;
    mcen_d    = mcen_q;
    mwen_d    = mwen_q;
    rd_issue  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          rcen_d   = REG_RX;
          rd_issue = 1'b1;
          state_d  = CMD_RD;
        end
      end
      CMD_RD: begin
        if (uart_rack) begin
          rcen_d  = '0;
          cmd_d   = uart_rdata;
          rx_d    = uart_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        arg_idx_d = '0;
        xfer_d    = count_q;
        state_d   = IDLE;
        case (cmd_q)
          CMD_SET_ADDR, CMD_SET_COUNT: state_d = ARG_WAIT;
          CMD_READ_MEM: begin
            if (count_q != '0) begin
              mcen_d  = 1'b1;
              mwen_d  = 1'b0;
              state_d = MEM_RD;
            end
          end
          CMD_WRITE_MEM: begin
            if (count_q != '0) state_d = DATA_WAIT;
          end
          default: state_d = IDLE;
        endcase
      end
      ARG_WAIT: begin
        if (pend_q) begin
          rcen_d   = REG_RX;
          rd_issue = 1'b1;
          state_d  = ARG_RD;
        end
      end
      ARG_RD: begin
        if (uart_rack) begin
          rcen_d = '0;
          rx_d   = uart_rdata;
          if (cmd_q == CMD_SET_COUNT) begin
            count_d = uart_rdata;
            state_d = IDLE;
          end else if (arg_idx_q == 2'd3) begin
            // ADDR only changes once all four bytes are in
            addr_d  = {arg_sh_q, uart_rdata};
            state_d = IDLE;
          end else begin
            arg_sh_d  = {arg_sh_q[15:0], uart_rdata};
            arg_idx_d = arg_idx_q + 2'd1;
            state_d   = ARG_WAIT;
          end
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          mcen_d  = 1'b0;
          addr_d  = addr_q + 32'd1;
          wdata_d = mem_rdata;
          wcen_d  = REG_TX;
          state_d = TX_WR;
        end
      end
      TX_WR: begin
        if (uart_wack) begin
          wcen_d = '0;
          xfer_d = xfer_q - 8'd1;
          if (xfer_q == 8'd1) begin
            state_d = IDLE;
          end else begin
            mcen_d  = 1'b1;
            mwen_d  = 1'b0;
            state_d = MEM_RD;
          end
        end
      end
      DATA_WAIT: begin
        if (pend_q) begin
          rcen_d   = REG_RX;
          rd_issue = 1'b1;
          state_d  = DATA_RD;
        end
      end
      DATA_RD: begin
        if (uart_rack) begin
          rcen_d  = '0;
          rx_d    = uart_rdata;
          mcen_d  = 1'b1;
          mwen_d  = 1'b1;
          state_d = MEM_WR;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          mcen_d = 1'b0;
          mwen_d = 1'b0;
          addr_d = addr_q + 32'd1;
          xfer_d = xfer_q - 8'd1;
          state_d = (xfer_q == 8'd1) ? IDLE : DATA_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new interrupt wins over the clear so a byte arriving on the issue edge is kept
    pend_d = uart_interrupt | (pend_q & ~rd_issue);
  end

  // State registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      cmd_q     <= '0;
      arg_idx_q <= '0;
      arg_sh_q  <= '0;
      xfer_q    <= '0;
      rx_q      <= '0;
      rcen_q    <= '0;
      wcen_q    <= '0;
      wdata_q   <= '0;
      mcen_q    <= 1'b0;
      mwen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      cmd_q     <= cmd_d;
      arg_idx_q <= arg_idx_d;
      arg_sh_q  <= arg_sh_d;
      xfer_q    <= xfer_d;
      rx_q      <= rx_d;
      rcen_q    <= rcen_d;
      wcen_q    <= wcen_d;
      wdata_q   <= wdata_d;
      mcen_q    <= mcen_d;
      mwen_q    <= mwen_d;
    end
  end

  assign uart_rcen  = rcen_q;
  assign uart_wcen  = wcen_q;
  assign uart_wdata = wdata_q;
  assign mem_cen    = mcen_q;
  assign mem_wen    = mwen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = rx_q;

endmodule

// File: tb/tb_ucore_main.sv
// Scoreboard bench for ucore_main: stimulus tasks push expected bus events
// from a command-level reference model; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_ucore_main;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        uart_interrupt;
  logic [3:0]  uart_rcen;
  logic        uart_rack;
  logic [7:0]  uart_rdata;
  logic [3:0]  uart_wcen;
  logic        uart_wack;
  logic [7:0]  uart_wdata;
  logic        mem_cen;
  logic        mem_wen;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  ucore_main dut (
    .clk(clk), .aresetn(aresetn), .uart_interrupt(uart_interrupt),
    .uart_rcen(uart_rcen), .uart_rack(uart_rack), .uart_rdata(uart_rdata),
    .uart_wcen(uart_wcen), .uart_wack(uart_wack), .uart_wdata(uart_wdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [7:0]  data;
  } ev_t;

  localparam logic [1:0] EV_RX = 2'd0, EV_MRD = 2'd1, EV_MWR = 2'd2, EV_TX = 2'd3;

  ev_t         exp_q[$];
  logic [7:0]  rx_feed[$];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_addr = '0;
  logic [7:0]  m_count = '0;
  logic [7:0]  m_mem[logic [31:0]];
  logic [7:0]  env_mem[logic [31:0]];

  logic [7:0]  rx_cur = '0;
  int          rx_reads = 0;
  bit          drv_busy = 1'b0;
  bit          fast = 1'b0;
  bit          mem_hold = 1'b0;

  function automatic logic [7:0] bg(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] m_rd(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : bg(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  task automatic push_ev(input logic [1:0] k, input logic [31:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_rx(input logic [7:0] b);
    push_ev(EV_RX, 32'd0, b);
    rx_feed.push_back(b);
  endtask

  task automatic cmd_set_addr(input logic [31:0] a);
    send_rx(8'h01);
    send_rx(a[31:24]); send_rx(a[23:16]); send_rx(a[15:8]); send_rx(a[7:0]);
    m_addr = a;
  endtask

  task automatic cmd_set_count(input logic [7:0] c);
    send_rx(8'h02);
    send_rx(c);
    m_count = c;
  endtask

  task automatic cmd_read();
    logic [7:0] d;
    send_rx(8'h03);
    for (int i = 0; i < int'(m_count); i++) begin
      d = m_rd(m_addr);
      push_ev(EV_MRD, m_addr, d);
      push_ev(EV_TX, 32'd0, d);
      m_addr = m_addr + 32'd1;
    end
  endtask

  task automatic cmd_write(input logic [7:0] first, input bit use_first);
    logic [7:0] b;
    send_rx(8'h04);
    for (int i = 0; i < int'(m_count); i++) begin
      b = (use_first && i == 0) ? first : 8'($urandom);
      send_rx(b);
      push_ev(EV_MWR, m_addr, b);
      m_mem[m_addr] = b;
      m_addr = m_addr + 32'd1;
    end
  endtask

  // Wait until every byte is delivered and every expected event seen, then check ADDR
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((rx_feed.size() != 0 || drv_busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: pending events %0d, expected none", nm, exp_q.size());
      exp_q.delete();
      rx_feed.delete();
    end
    repeat (4) @(negedge clk);
    #3 chk({nm, "_addr"}, 64'(mem_addr), 64'(m_addr));
  endtask

  // ---------------- RX byte driver ----------------
  initial begin
    int n;
    int prev;
    uart_interrupt = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_feed.size() > 0 && aresetn) begin
        drv_busy = 1'b1;
        rx_cur = rx_feed.pop_front();
        prev = rx_reads;
        uart_interrupt = 1'b1;
        @(negedge clk);
        uart_interrupt = 1'b0;
        n = 0;
        while (rx_reads == prev && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (n >= 2000) begin
          checks++; errors++;
          $display("FAIL rx_consume: byte %h never read, expected an RX read", rx_cur);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drv_busy = 1'b0;
      end
    end
  end

  // ---------------- UART read responder ----------------
  initial begin
    int dly;
    dly = 0;
    uart_rack = 1'b0;
    uart_rdata = '0;
    forever begin
      @(negedge clk);
      if (!aresetn || uart_rack) begin
        uart_rack = 1'b0;
        uart_rdata = 8'($urandom);
      end else if (uart_rcen != 4'd0) begin
        if (dly == 0 || fast) begin
          uart_rack = 1'b1;
          uart_rdata = rx_cur;
          rx_reads++;
          dly = $urandom_range(0, 2);
        end else dly--;
      end else uart_rdata = 8'($urandom);
    end
  end

  // ---------------- UART write responder ----------------
  initial begin
    int dly;
    dly = 0;
    uart_wack = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn || uart_wack) uart_wack = 1'b0;
      else if (uart_wcen != 4'd0) begin
        if (dly == 0) begin
          uart_wack = 1'b1;
          dly = $urandom_range(0, 2);
        end else dly--;
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    int dly;
    dly = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!aresetn || mem_ack) begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
      end else if (mem_cen && !mem_hold) begin
        if (dly == 0) begin
          mem_ack = 1'b1;
          if (mem_wen) env_mem[mem_addr] = mem_wdata;
          else mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : bg(mem_addr);
          dly = $urandom_range(0, 2);
        end else dly--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic compare(input string nm, input logic [1:0] k, input logic [31:0] a,
                         input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: got kind=%0d addr=%h data=%h expected no event", nm, k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL %s: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                 nm, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  initial begin
    bit          mp_valid, tp_valid;
    logic [31:0] mp_addr;
    logic        mp_wen;
    logic [7:0]  mp_wdata, tp_wdata;
    int          act;
    mp_valid = 1'b0; tp_valid = 1'b0;
    mp_addr = '0; mp_wen = 1'b0; mp_wdata = '0; tp_wdata = '0;
    forever begin
      @(negedge clk);
      #2;
      act = int'(uart_rcen != 4'd0) + int'(uart_wcen != 4'd0) + int'(mem_cen);
      checks++;
      if (act > 1 || !(uart_rcen inside {4'b0000, 4'b0001}) ||
          !(uart_wcen inside {4'b0000, 4'b0010})) begin
        errors++;
        $display("FAIL req_onehot: got rcen=%b wcen=%b mem_cen=%b expected one RX/TX/mem request at most",
                 uart_rcen, uart_wcen, mem_cen);
      end
      if (mp_valid && mem_cen)
        chk("mem_stable", {mp_wen, mp_wdata, mp_addr}, {mem_wen, mem_wdata, mem_addr});
      if (tp_valid && uart_wcen != 4'd0)
        chk("tx_stable", 64'(uart_wdata), 64'(tp_wdata));
      mp_valid = mem_cen && !mem_ack;
      mp_addr = mem_addr; mp_wen = mem_wen; mp_wdata = mem_wdata;
      tp_valid = (uart_wcen != 4'd0) && !uart_wack;
      tp_wdata = uart_wdata;
      if (uart_rcen != 4'd0 && uart_rack) compare("rx_read", EV_RX, 32'd0, uart_rdata);
      if (uart_wcen != 4'd0 && uart_wack) compare("tx_write", EV_TX, 32'd0, uart_wdata);
      if (mem_cen && mem_ack) begin
        if (mem_wen) compare("mem_write", EV_MWR, mem_addr, mem_wdata);
        else compare("mem_read", EV_MRD, mem_addr, mem_rdata);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    #3 chk("reset_out", {uart_rcen, uart_wcen, uart_wdata, mem_cen, mem_wen, mem_wdata, mem_addr},
           64'd0);
    aresetn = 1'b1;

    // Two NOPs then SET_COUNT 0x80 with single-cycle rack; COUNT proven by a 128-byte read
    fast = 1'b1;
    send_rx(8'h00); send_rx(8'h00); cmd_set_count(8'h80);
    wait_idle("nop_count");
    fast = 1'b0;
    cmd_read();
    wait_idle("read128");

    // SET_ADDR then zero-length read leaves ADDR untouched
    cmd_set_addr(32'hABCDEF11); cmd_set_count(8'h00); cmd_read();
    wait_idle("set_addr");

    // Two-byte read from preset memory
    m_mem[32'h10] = 8'h5A; env_mem[32'h10] = 8'h5A;
    m_mem[32'h11] = 8'hA5; env_mem[32'h11] = 8'hA5;
    cmd_set_addr(32'h10); cmd_set_count(8'h02); cmd_read();
    wait_idle("read2");

    // Single-byte write
    cmd_set_addr(32'h20); cmd_set_count(8'h01); cmd_write(8'h3C, 1'b1);
    wait_idle("write1");
    chk("write1_mem", 64'(env_mem.exists(32'h20) ? env_mem[32'h20] : 8'h00), 64'h3C);

    // Address wrap across 0xFFFFFFFF
    cmd_set_addr(32'hFFFFFFFF); cmd_set_count(8'h02); cmd_read();
    wait_idle("wrap");

    // Zero-length write and an out-of-range command
    cmd_set_count(8'h00); cmd_write(8'h00, 1'b0); send_rx(8'hC7);
    wait_idle("zero_write");

    // Reset while a memory read is stalled
    cmd_set_addr(32'h40); cmd_set_count(8'h01);
    wait_idle("pre_reset");
    mem_hold = 1'b1;
    send_rx(8'h03);
    r = 0;
    while (!mem_cen && r < 2000) begin
      @(negedge clk);
      r++;
    end
    chk("stall_mem_cen", 64'(mem_cen), 64'd1);
    @(negedge clk);
    #3 aresetn = 1'b0;
    #1 chk("midreset_out",
           {uart_rcen, uart_wcen, uart_wdata, mem_cen, mem_wen, mem_wdata, mem_addr}, 64'd0);
    exp_q.delete();
    m_addr = '0; m_count = '0;
    mem_hold = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    repeat (20) @(negedge clk);
    #3 chk("post_reset_idle", {uart_rcen, uart_wcen, mem_cen, mem_addr}, 64'd0);
    cmd_read();
    cmd_set_addr(32'h30); cmd_set_count(8'h02); cmd_read();
    wait_idle("recover");

    // Randomized command mix over a small window so writes are read back
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          logic [7:0] b;
          b = 8'($urandom_range(5, 255));
          send_rx(($urandom_range(0, 1) == 0) ? 8'h00 : b);
        end
        2: begin
          if ($urandom_range(0, 3) == 0) cmd_set_addr(32'hFFFFFFFE);
          else cmd_set_addr(32'h100 + 32'($urandom_range(0, 15)));
        end
        3: cmd_set_count(8'($urandom_range(0, 4)));
        4, 5, 9: cmd_read();
        default: cmd_write(8'h00, 1'b0);
      endcase
      if (it % 10 == 9) wait_idle("random");
    end
    wait_idle("final");
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucore_main.md
UCORE_MAIN -- requirements
Module: ucore_main

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- uart_interrupt  in  1  one-cycle pulse: RX byte available.
- uart_rcen  out  4  one-hot UART register read request: [0]=RX, [1]=TX, [2]=STATUS, [3]=CTRL.
- uart_rack  in  1  read acknowledge.
- uart_rdata  in  8  read data, valid when uart_rack=1.
- uart_wcen  out  4  one-hot UART register write request, same register map as uart_rcen.
- uart_wack  in  1  write acknowledge.
- uart_wdata  out  8  write data.
- mem_cen  out  1  memory request.
- mem_wen  out  1  1=write, 0=read; valid while mem_cen=1.
- mem_ack  in  1  memory acknowledge.
- mem_addr  out  32  byte address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid when mem_ack=1.

Function
REQ-003 Internal registers: ADDR (32 bit), COUNT (8 bit), PEND (1 bit), command and argument-index state.
REQ-004 PEND is set on any rising edge where uart_interrupt=1. It is cleared when the core issues an RX read. A second interrupt while PEND=1 is lost (no queue).
REQ-005 UART read handshake:
- Assert exactly one uart_rcen bit and hold it until uart_rack=1 is sampled.
- On that edge, capture uart_rdata and deassert uart_rcen.
- The next request starts no earlier than the following cycle.
REQ-006 UART write handshake: same rules as REQ-005 on uart_wcen/uart_wack. uart_wdata is stable throughout the request.
REQ-007 Memory handshake:
- Hold mem_cen, mem_wen, mem_addr and mem_wdata stable until mem_ack=1 is sampled.
- On that edge, capture mem_rdata (reads) and drop mem_cen.
REQ-008 Only the RX (bit 0) read and the TX (bit 1) write are ever issued. STATUS and CTRL are never accessed.
REQ-009 FSM states: IDLE, CMD_RD, DECODE, ARG_WAIT, ARG_RD, MEM_RD, TX_WR, DATA_WAIT, DATA_RD, MEM_WR.
REQ-010 IDLE: when PEND=1, go to CMD_RD (RX read). On ack, go to DECODE with the captured byte as the command.
REQ-011 Command 0x00 NOP: no action; return to IDLE.
REQ-012 Command 0x01 SET_ADDR: collect the next 4 RX bytes, MSB first, into ADDR. Each byte waits for PEND in ARG_WAIT, then is read in ARG_RD. ADDR is written whole after the 4th byte.
REQ-013 Command 0x02 SET_COUNT: collect the next RX byte into COUNT.
REQ-014 Command 0x03 READ_MEM: COUNT times:
- Memory read at ADDR.
- TX write of the returned byte.
- ADDR += 1.
REQ-015 Command 0x04 WRITE_MEM: COUNT times:
- Wait for PEND, then RX read.
- Memory write of that byte to ADDR.
- ADDR += 1.
REQ-016 For READ_MEM/WRITE_MEM: COUNT=0 performs no transfers; COUNT is not modified; ADDR is left at its start value + COUNT.
REQ-017 ADDR increment wraps modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-018 Commands 0x05-0xFF are treated as NOP.
REQ-019 mem_addr always drives ADDR. mem_wdata drives the last RX byte.
REQ-020 All request outputs are registered. At most one of uart_rcen, uart_wcen, mem_cen is active in any cycle.

Reset
REQ-021 aresetn=0 immediately forces, regardless of clk:
- FSM to IDLE.
- ADDR=0, COUNT=0, PEND=0.
- uart_rcen=0, uart_wcen=0, uart_wdata=0.
- mem_cen=0, mem_wen=0, mem_wdata=0.
REQ-022 Reset mid-transaction abandons the transaction. No request is reasserted after release until a new command arrives.

Verification
REQ-023 Bytes 0x00, 0x00, 0x02, 0x80 (one interrupt per byte, rack one cycle after rcen[0]) -> exactly 4 RX reads, no memory/TX activity, COUNT=0x80.
REQ-024 Bytes 0x01, 0xAB, 0xCD, 0xEF, 0x11, then 0x02, 0x00, 0x03 -> no transfers, mem_addr=0xABCDEF11.
REQ-025 SET_ADDR 0x00000010, SET_COUNT 0x02, cmd 0x03, memory holds [0x10]=0x5A, [0x11]=0xA5 -> reads at 0x10 then 0x11 (mem_wen=0), TX writes 0x5A then 0xA5 on wcen[1], final mem_addr=0x12.
REQ-026 SET_ADDR 0x00000020, SET_COUNT 0x01, cmd 0x04, data byte 0x3C -> one memory write, mem_wen=1, mem_addr=0x20, mem_wdata=0x3C.
REQ-027 SET_ADDR 0xFFFFFFFF, SET_COUNT 0x02, cmd 0x03 -> reads at 0xFFFFFFFF then 0x00000000.
REQ-028 Reset asserted while mem_cen=1 and mem_ack withheld -> all outputs 0 immediately; after release, core idle until the next interrupt; ADDR=0.
